// File: rtl/fpu_inflight_tracker_pkg.sv
// Shared types and sizing for the FP in-flight destination scoreboard.
package fpu_inflight_tracker_pkg;

    localparam int FpuInflightSlots = 6;
    localparam int FpuLatW          = 4;
    localparam int FpRegW           = 5;

    typedef struct packed {
        logic              valid;
        logic [FpRegW-1:0] dest;
        logic [FpuLatW-1:0] count;
    } fpu_inflight_slot_t;

endpackage

// File: rtl/fpu_inflight_slot.sv
// One scoreboard slot: loads on allocate, counts down when the FPU advances, retires at count==1.
module fpu_inflight_slot
    import fpu_inflight_tracker_pkg::*;
#(
    parameter int LAT_W = FpuLatW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [FpRegW-1:0] i_dest,
    input  logic [LAT_W-1:0]  i_latency,
    input  logic              i_stall,
    output logic              o_valid,
    output logic [FpRegW-1:0] o_dest
);

    logic              valid_q, valid_d;
    logic [FpRegW-1:0] dest_q, dest_d;
    logic [LAT_W-1:0]  count_q, count_d;

    always_comb begin
        valid_d = valid_q;
        dest_d  = dest_q;
        count_d = count_q;
        if (valid_q && !i_stall) begin
            if (count_q == LAT_W'(1)) begin
                valid_d = 1'b0;
                dest_d  = '0;
                count_d = '0;
            end else begin
                count_d = count_q - LAT_W'(1);
            end
        end
        // Only free slots are ever loaded, so this never collides with a countdown.
        if (i_load) begin
            valid_d = 1'b1;
            dest_d  = i_dest;
            count_d = (i_latency == '0) ? LAT_W'(1) : i_latency;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            dest_q  <= dest_d;
            count_q <= count_d;
        end
    end

    assign o_valid = valid_q;
    assign o_dest  = dest_q;

endmodule

// File: rtl/fpu_inflight_tracker.sv
// Tracks in-flight pipelined FP destinations for the hazard unit; allocator, full/overflow and RAW compare.
module fpu_inflight_tracker
    import fpu_inflight_tracker_pkg::*;
#(
    parameter int NUM_SLOTS = FpuInflightSlots,
    parameter int LAT_W     = FpuLatW
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_issue,
    input  logic [4:0]                  i_issue_dest,
    input  logic [LAT_W-1:0]            i_issue_latency,
    input  logic                        i_flush,
    input  logic                        i_fpu_stall,
    input  logic [4:0]                  i_src1,
    input  logic [4:0]                  i_src2,
    input  logic [4:0]                  i_src3,
    input  logic [2:0]                  i_src_valid,
    output logic [NUM_SLOTS-1:0]        o_inflight_valid,
    output logic [NUM_SLOTS*FpRegW-1:0] o_inflight_dest,
    output logic                        o_full,
    output logic                        o_any_inflight,
    output logic                        o_raw_hit,
    output logic                        o_overflow
);

    logic [NUM_SLOTS-1:0]        valid;
    logic [NUM_SLOTS-1:0]        load;
    logic [NUM_SLOTS*FpRegW-1:0] dest;
    logic [2:0][FpRegW-1:0]      src;
    logic                        full, issue_ok, raw_hit;
    logic                        overflow_q, overflow_d;

    // Full looks only at registered valids, so a slot retiring this cycle is not reusable until the next.
    assign full     = &valid;
    assign issue_ok = i_issue & ~i_flush;
    assign src      = {i_src3, i_src2, i_src1};

    always_comb begin
        load = '0;
        if (issue_ok && !full) begin
            for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
                if (!valid[k]) begin
                    load    = '0;
                    load[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        fpu_inflight_slot #(.LAT_W(LAT_W)) u_slot (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_load   (load[k]),
            .i_dest   (i_issue_dest),
            .i_latency(i_issue_latency),
            .i_stall  (i_fpu_stall),
            .o_valid  (valid[k]),
            .o_dest   (dest[k*FpRegW +: FpRegW])
        );
    end

    assign overflow_d = overflow_q | (issue_ok & full);

    always_ff @(posedge i_clk) begin
        if (i_rst) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    // f0 is tracked like any other register: the match is qualified by valid, not by dest!=0.
    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            for (int s = 0; s < 3; s++) begin
                if (valid[k] && i_src_valid[s] && (dest[k*FpRegW +: FpRegW] == src[s])) raw_hit = 1'b1;
            end
        end
    end

    assign o_inflight_valid = valid;
    assign o_inflight_dest  = dest;
    assign o_full           = full;
    assign o_any_inflight   = |valid;
    assign o_raw_hit        = raw_hit;
    assign o_overflow       = overflow_q;

endmodule

// File: doc/fpu_inflight_tracker.md
Name: fpu_inflight_tracker

Overview:
- Scoreboard for pipelined FP ops (FADD/FSUB/FMUL/FMA, FDIV/FSQRT) between EX issue and FPU writeback.
- Holds up to NUM_SLOTS in-flight FP destinations, each with a per-slot latency countdown.
- Drives the fpu_inflight_dest_* fields of from_ex_comb, which feed the FP hazard logic in the hazard resolution unit.
- Also provides a RAW hit against the three PD-stage FP source registers.

Parameters:
- NUM_SLOTS, 6, number of tracked in-flight ops. Legal range 1..8.
- LAT_W, 4, width of the latency countdown. Maximum latency is 2^LAT_W-1.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_issue  in  1  a pipelined FP op advances into EX this cycle (already qualified by ~stall).
- i_issue_dest  in  5  FP destination register of the issuing op.
- i_issue_latency  in  LAT_W  cycles from issue until the result is forwardable.
- i_flush  in  1  pipeline flush; kills the op issuing this cycle.
- i_fpu_stall  in  1  FPU pipeline frozen; all countdowns hold.
- i_src1, i_src2, i_src3  in  5 each  PD-stage FP source registers.
- i_src_valid  in  3  per-source qualifier, bit0 = src1.
- o_inflight_valid  out  NUM_SLOTS  slot occupied.
- o_inflight_dest  out  NUM_SLOTS*5  slot k destination at bits [5k+4:5k]; 0 when the slot is empty.
- o_full  out  1  no free slot.
- o_any_inflight  out  1  OR of o_inflight_valid.
- o_raw_hit  out  1  a valid source matches a valid slot destination.
- o_overflow  out  1  sticky error flag.

Behaviour:
- Reset (i_rst=1 at a posedge): all slots invalid, dest=0, count=0, o_overflow=0. All outputs read 0 in the following cycle. i_rst overrides any concurrent issue or retire.
- Slot state (registered): valid, dest[4:0], count[LAT_W-1:0].
- Allocation:
  - Uses the registered free vector from the start of the cycle.
  - On i_issue & ~i_flush & ~o_full, the lowest-index free slot loads valid=1, dest=i_issue_dest, count=max(i_issue_latency,1).
  - A latency of 0 is treated as 1.
  - The entry is visible in outputs the cycle after issue. Same-cycle visibility for the issuing op is the hazard unit's entering-EX term, not this block's.
- Countdown:
  - Each cycle with ~i_fpu_stall, every valid slot decrements count.
  - A slot with count==1 and ~i_fpu_stall clears valid and dest at the posedge.
  - With i_fpu_stall=1, all counts and valid bits hold.
- Lifetime: an op issued at edge T with latency L and no stalls is valid for exactly L cycles after T. Each stalled cycle extends this by 1.
- Simultaneous retire and issue: a slot retiring in cycle N is not allocatable in cycle N. It is free in N+1. Consequently o_full has no combinational dependence on this cycle's retires.
- Full: o_full = &valid (registered state).
  - i_issue & ~i_flush & o_full drops the op and sets o_overflow=1.
  - o_overflow stays set until reset.
  - The hazard unit stalls EX issue on o_full, so this case is illegal in normal operation.
- Flush: i_flush only suppresses this cycle's allocation. Already-valid slots are older than the flush point and keep counting down.
- Duplicate destinations: multiple slots may hold the same dest. No merging.
- o_raw_hit: OR over k and s of (valid[k] & i_src_valid[s] & dest[k]==src_s). Purely combinational from registered state. f0 is matched like any other register, via valid, not dest!=0.
- o_inflight_dest fields are registered outputs with no combinational path from inputs.

Decomposition:
- riscv_pkg gains:
  - typedef fpu_inflight_slot_t {valid, dest[4:0], count}.
  - localparam FpuInflightSlots=6.
- Sub-module fpu_inflight_slot: one slot's load, decrement and retire logic, instantiated NUM_SLOTS times.
- Top level holds the priority allocator, full/overflow logic, and the RAW compare tree.

Test Plan:
- Reset: hold i_rst 2 cycles with i_issue=1 -> all outputs 0, o_overflow=0.
- Issue dest=5, lat=3, no stall -> slot0 valid with dest=5 for exactly 3 cycles, then 0. o_raw_hit=1 with src2=5 and i_src_valid=3'b010 during that window.
- Latency and f0: issue dest=0, lat=0 -> slot0 valid for 1 cycle, and o_raw_hit=1 for src1=0 during that cycle.
- Fill and overflow: six issues (dest 1..6, lat=15) -> o_full=1 after the 6th. A 7th issue sets o_overflow, and slots are unchanged.
- Stall and flush: issue lat=2, hold i_fpu_stall 3 cycles -> slot lives 5 cycles. An issue with i_flush=1 -> no slot is allocated.
- Same-cycle retire and issue:
  - Slot0 retires while slot1..5 are full and an issue arrives -> o_full=1, so the op is dropped and o_overflow=1.
  - Repeat with a 5-slot fill -> the issue goes to slot5, and slot0 is free the next cycle.
